// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - sequential shift-add multiplier, start/ok handshake; MUL_SIGNED_EN selects two's-complement mode
module mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   P,
  output logic                 ok,
  output logic                 done,
  output logic                 ovf
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_p;
  logic               r_ovf;
  logic               r_done;

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_p_next;
  logic               w_ovf_next;

  // One partial-product step: add the multiplicand when the current multiplier LSB is set
  assign w_sum  = {1'b0, r_acc_hi} + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_prod = {r_acc_hi, r_mplier};

`ifdef MUL_SIGNED_EN
  logic r_sgn;

  // Operands are reduced to unsigned magnitudes; 2^(WIDTH-1) maps onto itself as unsigned
  assign w_a_mag    = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign w_b_mag    = B[WIDTH-1] ? (~B + 1'b1) : B;
  assign w_p_next   = r_sgn ? (~w_prod + 1'b1) : w_prod;
  assign w_ovf_next = ~((&w_p_next[2*WIDTH-1:WIDTH-1]) | ~(|w_p_next[2*WIDTH-1:WIDTH-1]));

  // Result sign captured at accept so the magnitude product can be negated at the end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sgn <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_sgn <= A[WIDTH-1] ^ B[WIDTH-1];
    end
  end
`else
  assign w_a_mag    = A;
  assign w_b_mag    = B;
  assign w_p_next   = w_prod;
  assign w_ovf_next = |w_prod[2*WIDTH-1:WIDTH];
`endif

  // Control FSM and datapath; DONE spans two cycles: result load with done pulse, then return to IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc_hi <= '0;
      r_cnt    <= '0;
      r_p      <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_acc_hi <= '0;
            r_cnt    <= CW'(WIDTH - 1);
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc_hi <= w_sum[WIDTH:1];
          r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
          if (r_cnt == '0) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (!r_done) begin
            r_p    <= w_p_next;
            r_ovf  <= w_ovf_next;
            r_done <= 1'b1;
          end else begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign P    = r_p;
  assign ovf  = r_ovf;
  assign done = r_done;
  assign ok   = (r_state == S_IDLE);

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - self-checking bench for mul_seq against a latency/arithmetic model; honours MUL_SIGNED_EN
module tb_mul_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [2*W-1:0] P;
  logic          ok;
  logic          done;
  logic          ovf;

  int n_tot = 0;
  int n_bad = 0;

  mul_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .P     (P),
    .ok    (ok),
    .done  (done),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference product and overflow flag from plain arithmetic
  function automatic logic [64:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic        o;
`ifdef MUL_SIGNED_EN
    longint sa, sb, sp;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sp = sa * sb;
    p  = 64'(sp);
    o  = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
`else
    p = {32'd0, a} * {32'd0, b};
    o = (p[63:32] != 32'd0);
`endif
    return {o, p};
  endfunction

  // Model: accept when idle, result and done after W+1 edges, idle again after W+2 edges
  bit          m_valid = 0;
  int          m_age = -1;
  logic [63:0] m_p = '0;
  logic        m_ovf = 1'b0;
  logic        m_done = 1'b0;
  logic [64:0] m_pend = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid = 1;
      m_age   = -1;
      m_p     = '0;
      m_ovf   = 1'b0;
      m_done  = 1'b0;
    end else if (m_valid) begin
      m_done = 1'b0;
      if (m_age < 0) begin
        if (start) begin
          m_age  = 0;
          m_pend = ref_mul(A, B);
        end
      end else begin
        m_age++;
        if (m_age == W + 1) begin
          m_p    = m_pend[63:0];
          m_ovf  = m_pend[64];
          m_done = 1'b1;
        end else if (m_age == W + 2) begin
          m_age = -1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_ok",   64'(ok),   64'(m_age < 0));
      chk("cyc_done", 64'(done), 64'(m_done));
      chk("cyc_P",    P,         m_p);
      chk("cyc_ovf",  64'(ovf),  64'(m_ovf));
    end
  end

  task automatic wait_ok();
    int n;
    n = 0;
    while (!ok && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_ok", 64'(ok), 64'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 100);
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp_p, input logic exp_o);
    int n;
    wait_ok();
    start = 1'b1; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_busy"}, 64'(ok), 64'd0);
    A = $urandom; B = $urandom;
    wait_done(n);
    chk({nm, "_lat"}, 64'(n), 64'(W + 1));
    chk({nm, "_P"}, P, exp_p);
    chk({nm, "_ovf"}, 64'(ovf), 64'(exp_o));
    @(posedge clk); #1;
    chk({nm, "_ok_after"}, 64'(ok), 64'd1);
    chk({nm, "_done_low"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    // 1. reset then idle
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk("rst_P", P, 64'd0);
    chk("rst_ok", 64'(ok), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("idle_P", P, 64'd0);
    chk("idle_ok", 64'(ok), 64'd1);

    // 2. basic
    do_op("basic", 32'd12345, 32'd6789, 64'd83810205, 1'b0);

    // 3. max operands and zero
`ifdef MUL_SIGNED_EN
    do_op("max", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1, 1'b0);
`else
    do_op("max", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b1);
`endif
    do_op("zero", 32'd0, 32'hFFFFFFFF, 64'd0, 1'b0);

    // 4. back-to-back with operand change mid-run
    wait_ok();
    start = 1'b1; A = 32'd3; B = 32'd5;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1 A = 32'd7; B = 32'd9;
    wait_done(n);
    chk("b2b_first_P", P, 64'd15);
    wait_done(n);
    chk("b2b_second_P", P, 64'd63);
    start = 1'b0;
    @(posedge clk); #1;

    // 5. reset mid-operation
    wait_ok();
    start = 1'b1; A = 32'd100; B = 32'd200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("midrst_ok", 64'(ok), 64'd1);
    chk("midrst_P", P, 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_noresult", P, 64'd0);
    do_op("after_rst", 32'd2, 32'd3, 64'd6, 1'b0);

`ifdef MUL_SIGNED_EN
    // 6. signed mode
    do_op("s_neg", 32'hFFFFFFF9, 32'd6, 64'hFFFFFFFFFFFFFFD6, 1'b0);
    do_op("s_minmin", 32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b1);
    do_op("s_minone", 32'h80000000, 32'd1, 64'hFFFFFFFF80000000, 1'b0);
`else
    do_op("u_big", 32'h80000000, 32'd2, 64'h0000000100000000, 1'b1);
    do_op("u_fit", 32'h0000FFFF, 32'h00010001, 64'h00000000FFFFFFFF, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
